audio_sample_serializer: RTL
============================

// Module: audio_sample_serializer
// PURPOSE
//   Next-generation audio receive path. Buffers recorded PCM samples (nominally 12 kHz)
//   in an on-chip FIFO. On record_done, streams the buffer out on a 1-bit serial line,
//   one UART-style frame per sample.
//   Sits between the microphone/ADC sample source and the serial link/transmit stage.
// PARAMETERS
//   SAMPLE_WIDTH  8     bits per audio sample (audio_in width, data bits per frame)
//   DEPTH         4096  FIFO capacity in samples; need not be a power of 2
//   BIT_CYCLES    8     clk_in cycles each serial bit is held on out (>=1)
// PORTS
//   clk_in          in   1                        system clock; single clock domain
//   rst_in          in   1                        asynchronous, active-high reset
//   record_done     in   1                        1-cycle pulse: recording ended, begin playback
//   audio_in        in   SAMPLE_WIDTH             sample data, valid when audio_valid_in=1
//   audio_valid_in  in   1                        1-cycle sample strobe
//   valid_out       out  1                        high while out carries a frame bit
//   out             out  1                        serial line; idles 1
//   busy_out        out  1                        high in SEND state
//   done_out        out  1                        1-cycle pulse when playback finishes
//   overflow_out    out  1                        sticky: a sample was dropped (FIFO full)
//   count_out       out  $clog2(DEPTH+1)          samples currently buffered
// BEHAVIOUR
//   Reset (async assert, sync release): state=CAPTURE.
//     out=1, valid_out=0, busy_out=0, done_out=0, overflow_out=0, count_out=0, FIFO empty.
//   All outputs are registered.
//   CAPTURE:
//     - audio_valid_in & !full: write audio_in, count+1.
//     - audio_valid_in & full: sample dropped, overflow_out<=1.
//     - record_done & (count>0 or same-cycle write): -> SEND.
//       A sample strobed in the same cycle as record_done is stored first and is sent.
//     - record_done & empty & no write: done_out pulses next cycle; stay in CAPTURE.
//   SEND:
//     - audio_valid_in and record_done are ignored; nothing is written.
//     - Pop head sample into shift register; emit frame:
//       start(0), data MSB-first, [parity], stop(1).
//     - Each bit held exactly BIT_CYCLES cycles; valid_out=1 for the whole frame.
//     - Latency: first start bit appears on out the cycle after record_done is sampled.
//     - Frames are back-to-back: the next start bit follows the last stop-bit cycle
//       with no idle gap while FIFO non-empty.
//     - count_out decrements on each pop.
//     - After the last stop bit with FIFO empty: out=1, valid_out=0, done_out=1 for 1 cycle,
//       overflow_out cleared, -> CAPTURE.
//   FIFO: circular RAM, wr/rd pointers wrap DEPTH-1 -> 0. full: count==DEPTH. empty: count==0.
//   Counters: bit-cycle counter $clog2(BIT_CYCLES+1) bits.
//     Bit index counts frame bits (SAMPLE_WIDTH+2, +1 with parity).
//   Reset mid-operation: any state, any bit position -> reset values immediately;
//     buffered samples discarded.
// CONFIGURATION
//   AUDIO_SER_PARITY_EN defined:
//     - even-parity bit (XOR of data bits) inserted between last data bit and stop bit.
//     - frame = SAMPLE_WIDTH+3 bits.
//   Undefined:
//     - no parity bit; frame = SAMPLE_WIDTH+2 bits; no parity logic synthesised.
// TESTING (SAMPLE_WIDTH=8, DEPTH=4, BIT_CYCLES=2 unless noted)
//   1. Write 0xA5, record_done ->
//      out = 0,1,0,1,0,0,1,0,1,1, each bit 2 cycles; valid_out high 20 cycles;
//      done_out pulse; count_out 1->0.
//   2. Write 0x01,0x02,0x03,0x04,0x05 ->
//      5th dropped, overflow_out=1, count_out=4; record_done -> 4 frames back-to-back,
//      80 contiguous valid_out cycles; overflow_out=0 after done_out.
//   3. record_done with empty FIFO -> done_out pulse next cycle; valid_out/busy_out stay 0.
//   4. audio_valid_in (0x3C) same cycle as record_done, FIFO empty ->
//      one frame carrying 0x3C is sent.
//   5. rst_in asserted in mid data bit of frame 2 ->
//      same edge: out=1, valid_out=0, count_out=0; new capture works normally.
//   6. AUDIO_SER_PARITY_EN, write 0xA5 ->
//      parity bit 0, 11-bit frame (22 cycles); 0xA4 -> parity 1.

Source files
------------

// File: rtl/audio_sample_serializer.sv
// Buffers PCM samples in a circular FIFO and, on record_done, streams them out as UART-style frames.
// Optional even-parity bit per frame is enabled by defining AUDIO_SER_PARITY_EN.
`timescale 1ns/1ps
module audio_sample_serializer #(
   parameter int SAMPLE_WIDTH = 8,
   parameter int DEPTH        = 4096,
   parameter int BIT_CYCLES   = 8
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         record_done,
   input  logic [SAMPLE_WIDTH-1:0]      audio_in,
   input  logic                         audio_valid_in,
   output logic                         valid_out,
   output logic                         out,
   output logic                         busy_out,
   output logic                         done_out,
   output logic                         overflow_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
);

   localparam int CW  = $clog2(DEPTH+1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BCW = $clog2(BIT_CYCLES+1);
`ifdef AUDIO_SER_PARITY_EN
   localparam int FRAME_BITS = SAMPLE_WIDTH + 3;
`else
   localparam int FRAME_BITS = SAMPLE_WIDTH + 2;
`endif
   localparam int IW  = $clog2(FRAME_BITS);
   localparam int SHW = FRAME_BITS - 1;

   typedef enum logic {CAPTURE, SEND} state_t;

   state_t                  state_q, state_d;
   logic [SAMPLE_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [SHW-1:0]          shift_q, shift_d;
   logic [IW-1:0]           bit_idx_q, bit_idx_d;
   logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
   logic                    out_q, out_d, valid_q, valid_d, busy_q, busy_d;
   logic                    done_q, done_d, overflow_q, overflow_d;
   logic                    wr_en, pop, load, full;
   logic [SAMPLE_WIDTH-1:0] load_data;

   assign full = (count_q == CW'(DEPTH));

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      bit_cnt_d  = bit_cnt_q;
      out_d      = out_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
      pop        = 1'b0;
      load       = 1'b0;
      load_data  = mem_q[rd_ptr_q];

      case (state_q)
         CAPTURE: begin
            if (audio_valid_in) begin
               if (full) overflow_d = 1'b1;
               else      wr_en      = 1'b1;
            end
            if (record_done) begin
               if (count_q != '0) begin
                  load = 1'b1;
                  pop  = 1'b1;
               end else if (wr_en) begin
                  // Empty FIFO: the same-cycle sample goes straight to the shifter.
                  load      = 1'b1;
                  load_data = audio_in;
                  wr_en     = 1'b0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (bit_cnt_q == BCW'(BIT_CYCLES-1)) begin
               if (bit_idx_q == IW'(FRAME_BITS-1)) begin
                  if (count_q != '0) begin
                     load = 1'b1;
                     pop  = 1'b1;
                  end else begin
                     state_d    = CAPTURE;
                     out_d      = 1'b1;
                     valid_d    = 1'b0;
                     done_d     = 1'b1;
                     overflow_d = 1'b0;
                     bit_idx_d  = '0;
                     bit_cnt_d  = '0;
                  end
               end else begin
                  out_d     = shift_q[SHW-1];
                  shift_d   = {shift_q[SHW-2:0], 1'b1};
                  bit_idx_d = bit_idx_q + IW'(1);
                  bit_cnt_d = '0;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
         end
         default: state_d = CAPTURE;
      endcase

      // Loading a frame drives the start bit immediately; the shifter holds the rest.
      if (load) begin
         state_d   = SEND;
         out_d     = 1'b0;
         valid_d   = 1'b1;
`ifdef AUDIO_SER_PARITY_EN
         shift_d   = {load_data, ^load_data, 1'b1};
`else
         shift_d   = {load_data, 1'b1};
`endif
         bit_idx_d = '0;
         bit_cnt_d = '0;
      end

      if (wr_en) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      busy_d = (state_d == SEND);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= CAPTURE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         shift_q    <= '1;
         bit_idx_q  <= '0;
         bit_cnt_q  <= '0;
         out_q      <= 1'b1;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
      end
   end

   // Sample storage needs no reset; an empty count makes stale entries unreachable.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem_q[wr_ptr_q] <= audio_in;
   end

   assign out          = out_q;
   assign valid_out    = valid_q;
   assign busy_out     = busy_q;
   assign done_out     = done_q;
   assign overflow_out = overflow_q;
   assign count_out    = count_q;

endmodule
